row_skew_feeder: RTL and testbench
==================================

// Module: row_skew_feeder
// PURPOSE
// - Downstream neighbour of the row register file.
// - Reads N consecutive rows (MEM_LEN lanes x DATA_WIDTH each) over the file's read port.
// - Skews each row diagonally (lane j delayed j cycles) and drives the systolic array's
//   west/north edge. Lanes not carrying live data drive zero.
// - start/busy/done handshake to the FFN controller.
// PARAMETERS
// - DATA_WIDTH  16  bits per element/lane
// - MEM_LEN     16  lanes per row (array edge length)
// - MEM_DEPTH   16  rows in the register file
// - ADDR_W       4  read address width; equals $clog2(MEM_DEPTH)
// PORTS
// - clk        in   1                    clock, rising edge
// - rstn       in   1                    asynchronous active-low reset
// - start_i    in   1                    begin a feed; sampled in IDLE only
// - base_i     in   ADDR_W               first row address
// - nrows_i    in   ADDR_W+1             rows to feed (0..MEM_DEPTH)
// - busy_o     out  1                    high from the cycle after accept until done
// - done_o     out  1                    one-cycle completion pulse
// - rd_en_o    out  1                    register-file read enable
// - rd_addr_o  out  ADDR_W               register-file read address
// - rd_data_i  in   DATA_WIDTH*MEM_LEN   register-file row, valid 1 cycle after rd_en_o
// - data_o     out  DATA_WIDTH*MEM_LEN   skewed lanes; lane j = bits [j*DW +: DW]
// - valid_o    out  MEM_LEN              per-lane valid for data_o
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, all skew registers 0. Reset mid-feed aborts with no done pulse.
// - FSM states: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//   - IDLE: start_i=1 in cycle S latches base_i and nrows_i.
//     nrows_i > MEM_DEPTH is clamped to MEM_DEPTH. nrows_i = 0 goes to DONE.
//   - READ: cycles S+1 .. S+N. rd_en_o=1, rd_addr_o = base+k mod MEM_DEPTH (wraps 15->0).
//   - DRAIN: counts MEM_LEN+1 cycles with rd_en_o=0. Last valid lane is at cycle S+N+MEM_LEN+1.
//   - DONE: single cycle, done_o=1 at S+N+MEM_LEN+2, busy_o=0. Returns to IDLE.
//     A start_i in the DONE cycle is ignored.
// - busy_o = (state != IDLE && state != DONE). start_i while busy is ignored.
// - Read pipeline: a 1-bit rd_valid register follows rd_en_o by 1 cycle and qualifies rd_data_i capture.
// - Skew: lane j is a shift register of depth j+1 carrying {valid, data}.
//   - Stage 0 captures rd_data_i lane j when rd_valid=1, else captures {0, 0}.
//   - Row k lane j appears on data_o/valid_o in cycle S+3+k+j (registered output).
//   - valid_o[j]=0 forces that lane's data_o to 0.
// - No arithmetic on data; pass-through only. Address arithmetic is modulo 2^ADDR_W.
// - Source rows must be stable for the feed: the controller must not assert the file's wr_en while busy_o=1.
//   The file drops reads when written; this block does not detect that.
// - No back-pressure. The array consumes every cycle.
// STRUCTURE
// - ffn_pkg:
//   - constants DATA_WIDTH, MEM_LEN, MEM_DEPTH, ADDR_W
//   - typedef row_t = logic [DATA_WIDTH*MEM_LEN-1:0]
//   - typedef feed_state_e {IDLE, READ, DRAIN, DONE}
// - Sub-module skew_delay_line #(WIDTH, DEPTH):
//   - DEPTH-stage shift register with async reset.
//   - Instantiated per lane in a generate loop with DEPTH=j+1, WIDTH=DATA_WIDTH+1.
// - Top level holds the FSM, row/drain counters and rd_valid register.
// TESTING
// - Reset: rstn=0 mid-READ at row 3.
//   -> all outputs 0 next edge; no done_o; a new start after release behaves normally.
// - Basic feed: base=0, nrows=4, file row r lane j = {r[7:0], j[7:0]}.
//   -> lane j of row k on data_o at S+3+k+j; done_o at S+22; rd_en_o high exactly S+1..S+4.
// - Wrap: base=14, nrows=4.
//   -> rd_addr_o sequence 14, 15, 0, 1; data order matches.
// - Zero rows: nrows=0.
//   -> no rd_en_o; done_o at S+1; valid_o stays 0.
// - Clamp / full: nrows=20.
//   -> exactly 16 reads (base..base+15 mod 16); done_o at S+34.
// - Busy start: start_i pulsed at S+5 and in the DONE cycle.
//   -> ignored; a single done_o; no extra reads.

Source files
------------

// File: rtl/ffn_pkg.sv
// ffn_pkg: shared constants, types and helpers for the FFN datapath blocks.
//   DATA_WIDTH / MEM_LEN / MEM_DEPTH / ADDR_W : geometry of the row register file and array edge
//   row_t        : one full register-file row (MEM_LEN lanes of DATA_WIDTH bits)
//   feed_state_e : row_skew_feeder control states
//   clamp_rows() : limits a requested row count to the file depth
package ffn_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int MEM_LEN    = 16;
   localparam int MEM_DEPTH  = 16;
   localparam int ADDR_W     = $clog2(MEM_DEPTH);
   localparam int ROW_W      = DATA_WIDTH * MEM_LEN;
   localparam int CNT_W      = ADDR_W + 1;
   localparam int DRAIN_W    = $clog2(MEM_LEN + 1);

   typedef logic [ROW_W-1:0]  row_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } feed_state_e;

   function automatic cnt_t clamp_rows(cnt_t n);
      return (n > cnt_t'(MEM_DEPTH)) ? cnt_t'(MEM_DEPTH) : n;
   endfunction

endpackage

// File: rtl/row_skew_feeder_if.sv
// row_skew_feeder_if: controller handshake, register-file read port and array edge
// for row_skew_feeder.
//   start_i/base_i/nrows_i : feed request from the FFN controller
//   busy_o/done_o          : feed status back to the controller
//   rd_en_o/rd_addr_o      : read request to the row register file
//   rd_data_i              : row returned by the file one cycle after rd_en_o
//   data_o/valid_o         : diagonally skewed lanes towards the systolic array
// slave is the feeder's view; master is the view of everything around it.
interface row_skew_feeder_if;
   import ffn_pkg::*;

   logic                start_i;
   addr_t               base_i;
   cnt_t                nrows_i;
   logic                busy_o;
   logic                done_o;
   logic                rd_en_o;
   addr_t               rd_addr_o;
   row_t                rd_data_i;
   row_t                data_o;
   logic [MEM_LEN-1:0]  valid_o;

   modport slave (
      input  start_i, base_i, nrows_i, rd_data_i,
      output busy_o, done_o, rd_en_o, rd_addr_o, data_o, valid_o
   );

   modport master (
      output start_i, base_i, nrows_i, rd_data_i,
      input  busy_o, done_o, rd_en_o, rd_addr_o, data_o, valid_o
   );

endinterface

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register, used as one diagonal lane delay.
//   clk, rstn : clock and asynchronous active-low reset
//   din       : value entering stage 0
//   dout      : value leaving the last stage, DEPTH cycles later
module skew_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // NOTE: every stage is reset, not just the head; a stale valid bit left in
   // the middle of a lane after an aborted feed would surface on the array edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/row_skew_feeder.sv
// row_skew_feeder: reads N consecutive rows from the row register file and feeds
// them diagonally skewed (lane j delayed j cycles) onto the systolic array edge.
//   clk, rstn : clock and asynchronous active-low reset
//   bus       : row_skew_feeder_if.slave (controller handshake, file read port, array edge)
// Timing for a start accepted in cycle S with N rows: reads in S+1..S+N, row k lane j
// on the edge in S+3+k+j, done_o in S+N+MEM_LEN+2 (S+1 when N is 0).
module row_skew_feeder
   import ffn_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   row_skew_feeder_if.slave      bus
);

   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MEM_LEN);

   feed_state_e          state_q, state_d;
   addr_t                base_q, base_d;
   cnt_t                 nrows_q, nrows_d;
   cnt_t                 row_q, row_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic                 rd_valid_q;
   cnt_t                 nrows_clamped;
   cnt_t                 row_inc;

   assign nrows_clamped = clamp_rows(bus.nrows_i);
   assign row_inc       = row_q + cnt_t'(1);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         base_q     <= '0;
         nrows_q    <= '0;
         row_q      <= '0;
         drain_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         nrows_q    <= nrows_d;
         row_q      <= row_d;
         drain_q    <= drain_d;
         // Read data is returned one cycle after the request.
         rd_valid_q <= (state_q == READ);
      end
   end

   // NOTE: every signal written here gets its hold value first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      nrows_d = nrows_q;
      row_d   = row_q;
      drain_d = drain_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               base_d  = bus.base_i;
               nrows_d = nrows_clamped;
               row_d   = '0;
               drain_d = '0;
               state_d = (nrows_clamped == '0) ? DONE : READ;
            end
         end
         READ: begin
            row_d = row_inc;
            if (row_inc == nrows_q) state_d = DRAIN;
         end
         DRAIN: begin
            // MEM_LEN+1 cycles: the last row has to cross the deepest lane.
            drain_d = drain_q + DRAIN_W'(1);
            if (drain_q == DRAIN_LAST) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy_o    = (state_q == READ) || (state_q == DRAIN);
   assign bus.done_o    = (state_q == DONE);
   assign bus.rd_en_o   = (state_q == READ);
   // Address wraps naturally at MEM_DEPTH because it is ADDR_W bits wide.
   assign bus.rd_addr_o = (state_q == READ) ? addr_t'(base_q + row_q[ADDR_W-1:0]) : '0;

   row_t                data_w;
   logic [MEM_LEN-1:0]  valid_w;

   for (genvar j = 0; j < MEM_LEN; j++) begin : g_lane
      logic [DATA_WIDTH:0] lane_in;
      logic [DATA_WIDTH:0] lane_out;

      assign lane_in = rd_valid_q ? {1'b1, bus.rd_data_i[j*DATA_WIDTH +: DATA_WIDTH]} : '0;

      skew_delay_line #(
         .WIDTH (DATA_WIDTH + 1),
         .DEPTH (j + 1)
      ) u_delay (
         .clk  (clk),
         .rstn (rstn),
         .din  (lane_in),
         .dout (lane_out)
      );

      assign valid_w[j]                           = lane_out[DATA_WIDTH];
      assign data_w[j*DATA_WIDTH +: DATA_WIDTH]   = lane_out[DATA_WIDTH] ?
                                                    lane_out[DATA_WIDTH-1:0] : '0;
   end

   assign bus.data_o  = data_w;
   assign bus.valid_o = valid_w;

endmodule

// File: tb/tb_row_skew_feeder.sv
// tb_row_skew_feeder: self-checking bench for row_skew_feeder. A behavioural
// register file answers reads; each feed is checked cycle by cycle against
// expectations computed from the feed timing rules.
module tb_row_skew_feeder;
   import ffn_pkg::*;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   row_skew_feeder_if bus ();

   row_skew_feeder dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   row_t mem [MEM_DEPTH];

   // Register-file model: one-cycle read latency.
   always @(posedge clk) begin
      if (bus.rd_en_o) bus.rd_data_i <= mem[bus.rd_addr_o];
   end

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [ROW_W-1:0] act,
                        input logic [ROW_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   task automatic fill_pattern();
      for (int r = 0; r < MEM_DEPTH; r++)
         for (int j = 0; j < MEM_LEN; j++)
            mem[r][j*DATA_WIDTH +: DATA_WIDTH] = {8'(r), 8'(j)};
   endtask

   task automatic fill_random();
      for (int r = 0; r < MEM_DEPTH; r++)
         for (int j = 0; j < MEM_LEN; j++)
            mem[r][j*DATA_WIDTH +: DATA_WIDTH] = 16'($urandom);
   endtask

   // Expected outputs t cycles after the accept cycle for a feed of n rows from base.
   task automatic check_cycle(input int t, input int base, input int n);
      int                  last;
      logic                exp_en, exp_busy, exp_done;
      logic [MEM_LEN-1:0]  exp_valid;
      row_t                exp_data;
      last      = (n == 0) ? 1 : n + MEM_LEN + 2;
      exp_en    = (t >= 1) && (t <= n);
      exp_busy  = (n > 0) && (t >= 1) && (t < last);
      exp_done  = (t == last);
      exp_valid = '0;
      exp_data  = '0;
      for (int j = 0; j < MEM_LEN; j++) begin
         int k;
         k = t - 3 - j;
         if (k >= 0 && k < n) begin
            exp_valid[j] = 1'b1;
            exp_data[j*DATA_WIDTH +: DATA_WIDTH] =
               mem[(base + k) % MEM_DEPTH][j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      check($sformatf("rd_en t=%0d", t), ROW_W'(bus.rd_en_o), ROW_W'(exp_en));
      if (exp_en)
         check($sformatf("rd_addr t=%0d", t), ROW_W'(bus.rd_addr_o),
               ROW_W'((base + t - 1) % MEM_DEPTH));
      check($sformatf("busy t=%0d", t), ROW_W'(bus.busy_o), ROW_W'(exp_busy));
      check($sformatf("done t=%0d", t), ROW_W'(bus.done_o), ROW_W'(exp_done));
      check($sformatf("valid t=%0d", t), ROW_W'(bus.valid_o), ROW_W'(exp_valid));
      check($sformatf("data t=%0d", t), bus.data_o, exp_data);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"},  ROW_W'(bus.busy_o),    '0);
      check({tag, " done"},  ROW_W'(bus.done_o),    '0);
      check({tag, " rd_en"}, ROW_W'(bus.rd_en_o),   '0);
      check({tag, " addr"},  ROW_W'(bus.rd_addr_o), '0);
      check({tag, " valid"}, ROW_W'(bus.valid_o),   '0);
      check({tag, " data"},  bus.data_o,            '0);
   endtask

   // Issue one feed and check every cycle until two cycles past done.
   // poke_busy re-asserts start at t=5 and in the done cycle; both must be ignored.
   task automatic run_feed(input int base, input int nrows, input bit poke_busy);
      int n, last;
      n    = (nrows > MEM_DEPTH) ? MEM_DEPTH : nrows;
      last = (n == 0) ? 1 : n + MEM_LEN + 2;
      @(negedge clk);
      check("idle busy", ROW_W'(bus.busy_o), '0);
      check("idle valid", ROW_W'(bus.valid_o), '0);
      bus.start_i = 1'b1;
      bus.base_i  = addr_t'(base);
      bus.nrows_i = cnt_t'(nrows);
      for (int t = 1; t <= last + 2; t++) begin
         @(negedge clk);
         check_cycle(t, base, n);
         bus.start_i = poke_busy && (t == 5 || t == last);
         bus.base_i  = addr_t'($urandom);
         bus.nrows_i = cnt_t'($urandom_range(1, MEM_DEPTH));
      end
      bus.start_i = 1'b0;
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.base_i  = '0;
      bus.nrows_i = '0;
      fill_pattern();

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rstn = 1'b1;

      run_feed(0, 4, 1'b0);     // basic
      run_feed(14, 4, 1'b0);    // address wrap
      run_feed(5, 0, 1'b0);     // zero rows
      run_feed(3, 20, 1'b0);    // clamp to full depth
      run_feed(7, 4, 1'b1);     // start while busy / in done

      // Reset in the middle of READ, while row 3 is being requested.
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.base_i  = addr_t'(2);
      bus.nrows_i = cnt_t'(8);
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk);
         check_cycle(t, 2, 8);
         bus.start_i = 1'b0;
      end
      rstn = 1'b0;
      #1 check_all_zero("abort async");
      @(posedge clk);
      #1 check_all_zero("abort edge");
      @(negedge clk);
      rstn = 1'b1;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         check($sformatf("post-abort done c=%0d", t), ROW_W'(bus.done_o), '0);
         check($sformatf("post-abort valid c=%0d", t), ROW_W'(bus.valid_o), '0);
      end
      run_feed(9, 6, 1'b0);

      // Randomised feeds over random file contents.
      for (int i = 0; i < 10; i++) begin
         fill_random();
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_feed(int'($urandom_range(0, MEM_DEPTH - 1)), int'($urandom_range(0, 31)),
                  1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
